// File: rtl/dmem_if.sv
// Data-access interface between the memory stage and the data-memory responder.
// Carries two request lanes (valid, we, byte addr, store data, byte enables)
// downstream, and the stall plus per-lane registered responses back upstream.
//   master : memory stage (drives requests, observes stall/responses)
//   slave  : dmem_responder
interface dmem_if #(
  parameter int DATA_W = 32
);
  logic [1:0]                   req_valid;
  logic [1:0]                   req_we;
  logic [1:0][31:0]             req_addr;
  logic [1:0][DATA_W-1:0]       req_wdata;
  logic [1:0][DATA_W/8-1:0]     req_be;
  logic                         stall_out;
  logic [1:0]                   resp_valid;
  logic [1:0][DATA_W-1:0]       resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  stall_out, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output stall_out, resp_valid, resp_rdata
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder. Accepts a two-lane load/store pair, serves lane 0
// then lane 1 against a single-port word array (LATENCY cycles per access),
// then presents both lane results for one RESP cycle.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : dmem_if slave (requests in; stall_out, resp_valid, resp_rdata out)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a nonzero req_valid; latches the pair when it comes
// LANE0 | lane 0 access in progress, access performed on the last count
// LANE1 | lane 1 access in progress, access performed on the last count
// RESP  | one-cycle response; requests still held upstream are ignored
module dmem_responder #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam int         BE_W     = DATA_W / 8;
  localparam logic [1:0] CNT_LAST = 2'(LATENCY - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LANE0 = 2'd1;
  localparam logic [1:0] S_LANE1 = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]               state, state_nxt;
  logic [1:0]               cnt;
  logic [1:0]               lat_valid;
  logic [1:0]               lat_we;
  logic [1:0][31:0]         lat_addr;
  logic [1:0][DATA_W-1:0]   lat_wdata;
  logic [1:0][BE_W-1:0]     lat_be;
  logic [DATA_W-1:0]        res0;

  logic [DATA_W-1:0]        mem [DEPTH_WORDS];

  logic                     cur_lane;
  logic [IDX_W-1:0]         cur_idx;
  logic                     acc_last;
  logic                     do_write;
  logic [DATA_W-1:0]        rd_word;

  assign cur_lane = (state == S_LANE1);
  assign cur_idx  = lat_addr[cur_lane][IDX_W+1:2];
  assign acc_last = ((state == S_LANE0) || (state == S_LANE1)) && (cnt == CNT_LAST);
  assign rd_word  = mem[cur_idx];
  // Reset wins over an access landing in the same cycle.
  assign do_write = acc_last && lat_we[cur_lane] && !rst;

  // Byte-offset and above-index address bits are deliberately ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{lat_addr[0][31:IDX_W+2], lat_addr[0][1:0],
                              lat_addr[1][31:IDX_W+2], lat_addr[1][1:0]};

  assign bus.stall_out = ((state == S_IDLE) && (bus.req_valid != 2'b00)) ||
                         (state == S_LANE0) || (state == S_LANE1);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.req_valid != 2'b00) state_nxt = bus.req_valid[0] ? S_LANE0 : S_LANE1;
      S_LANE0: if (acc_last) state_nxt = lat_valid[1] ? S_LANE1 : S_RESP;
      S_LANE1: if (acc_last) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= 2'd0;
      lat_valid      <= '0;
      lat_we         <= '0;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      lat_be         <= '0;
      res0           <= '0;
      bus.resp_valid <= '0;
      bus.resp_rdata <= '0;
    end else begin
      state          <= state_nxt;
      bus.resp_valid <= '0;
      bus.resp_rdata <= '0;

      case (state)
        S_IDLE: begin
          if (bus.req_valid != 2'b00) begin
            lat_valid <= bus.req_valid;
            lat_we    <= bus.req_we;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            lat_be    <= bus.req_be;
            cnt       <= 2'd0;
          end
        end
        S_LANE0, S_LANE1: cnt <= acc_last ? 2'd0 : cnt + 2'd1;
        default: ;
      endcase

      if (acc_last && (state == S_LANE0) && !lat_we[0])
        res0 <= rd_word;

      // Responses are loaded on entry to RESP so they are only nonzero there.
      // The lane finishing right now has its load word bypassed from the array.
      if (state_nxt == S_RESP) begin
        bus.resp_valid <= lat_valid;
        if (lat_valid[0] && !lat_we[0])
          bus.resp_rdata[0] <= (state == S_LANE0) ? rd_word : res0;
        if (lat_valid[1] && !lat_we[1])
          bus.resp_rdata[1] <= rd_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < BE_W; b++) begin
        if (lat_be[cur_lane][b])
          mem[cur_idx][b*8 +: 8] <= lat_wdata[cur_lane][b*8 +: 8];
      end
    end
  end

endmodule
